serial_addsub_nbit: RTL and testbench
=====================================

SERIAL_ADDSUB_NBIT -- requirements
Module: serial_addsub_nbit

Interface
REQ-001 The block SHALL have parameter N, default 8, setting the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port clr, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled on the rising edge of clk.
REQ-005 The block SHALL have port sub, input, 1 bit: mode, 0 = A+B, 1 = A-B; sampled with start.
REQ-006 The block SHALL have port a, input, N bits: operand A, parallel-loaded with start.
REQ-007 The block SHALL have port b, input, N bits: operand B, parallel-loaded with start.
REQ-008 The block SHALL have port sum, output, N bits: result register; shift register A during an operation.
REQ-009 The block SHALL have port cout, output, 1 bit: final carry out of the MSB (for sub, 1 = no borrow).
REQ-010 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow of the result.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in state SHIFT.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 The datapath SHALL contain one 1-bit full adder, an N-bit shift register A, an N-bit shift register B, a carry flip-flop, and a shift counter of clog2(N+1) bits.
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-015 In IDLE, start=1 at an edge SHALL load A<=a, B<=(sub ? ~b : b), carry<=sub, count<=0, and move to SHIFT.
REQ-016 In IDLE, start=0 SHALL leave all registers unchanged.
REQ-017 In SHIFT, each edge SHALL perform: s=A[0]^B[0]^carry; A<={s,A[N-1:1]}; B<={1'b0,B[N-1:1]}; carry<=full-adder carry; count<=count+1.
REQ-018 On the shift edge where count==N-1, the FSM SHALL move to DONE; ovf SHALL load (carry-in to MSB) XOR (carry-out of MSB) and cout SHALL load the carry-out of MSB.
REQ-019 DONE SHALL last exactly one cycle with done=1; the next edge SHALL return to IDLE unconditionally.
REQ-020 Latency: with start accepted at edge t0, shift edges SHALL be t1..tN, done SHALL be high from tN to tN+1, and sum/cout/ovf SHALL be valid from tN.
REQ-021 sum, cout and ovf SHALL hold their values through DONE and IDLE until the next accepted start.
REQ-022 start SHALL be ignored in SHIFT and in DONE; a, b and sub SHALL be don't-care outside the accepting edge.
REQ-023 The result SHALL be (a + b) mod 2^N, or (a - b) mod 2^N when sub=1.
REQ-024 busy SHALL be high only in SHIFT; done SHALL be high only in DONE; busy and done SHALL never be high together.
REQ-025 While start is held high continuously, back-to-back operations SHALL start every N+2 cycles (load edge, N shifts, DONE).

Reset
REQ-026 clr=0 SHALL asynchronously force: state=IDLE; A, B, carry and count to 0; sum=0, cout=0, ovf=0, busy=0, done=0.
REQ-027 clr asserted mid-SHIFT or mid-DONE SHALL abort the operation with no done pulse; the block SHALL accept start on the first edge after clr deasserts.
REQ-028 clr deassertion SHALL not by itself start an operation.

Verification
REQ-029 The bench SHALL cover: N=8, a=0x35, b=0x4A, sub=0, one-cycle start -> busy for 8 cycles, done one cycle later, sum=0x7F, cout=0, ovf=0.
REQ-030 The bench SHALL cover: N=8, a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0.
REQ-031 The bench SHALL cover: N=8, a=0x7F, b=0x01, sub=0 -> sum=0x80, ovf=1; and a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
REQ-032 The bench SHALL cover: N=8, a=0x03, b=0x05, sub=1 -> sum=0xFE, cout=0, ovf=0.
REQ-033 The bench SHALL cover: clr pulsed low at shift 4 of an operation -> all outputs 0 immediately, no done; a new start then completes correctly.
REQ-034 The bench SHALL cover: start re-asserted during SHIFT -> ignored and the result unchanged; N=4 and N=16 random self-checked runs against a reference sum.

Source files
------------

// File: rtl/serial_addsub_nbit.sv
// Bit-serial N-bit adder/subtractor: one full adder processes one bit per clock,
// LSB first, with the result shifted into the A register.
module serial_addsub_nbit #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic           r_carry;
  logic [CW-1:0]  r_count;
  logic           r_cout;
  logic           r_ovf;
  logic           w_s;
  logic           w_c;
  logic           w_last;

  always_comb begin
    w_s    = r_a[0] ^ r_b[0] ^ r_carry;
    w_c    = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    w_last = (r_count == CW'(N - 1));
  end

  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub;
            r_count <= '0;
          end
        end
        SHIFT: begin
          r_a     <= {w_s, r_a[N-1:1]};
          r_b     <= {1'b0, r_b[N-1:1]};
          r_carry <= w_c;
          r_count <= r_count + CW'(1);
          if (w_last) begin
            // Final bit is the MSB: its carry-in vs carry-out gives signed overflow.
            r_cout <= w_c;
            r_ovf  <= r_carry ^ w_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_a;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);

endmodule

// File: tb/tb_serial_addsub_nbit.sv
// Self-checking bench for serial_addsub_nbit: N=8 directed cases, clr abort,
// start re-assertion, back-to-back timing, and random N=4/N=16 runs.
module tb_serial_addsub_nbit;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        v;
  } res_t;

  logic        clk;
  logic        clr;
  logic [2:0]  start_v;
  logic        sub;
  logic [15:0] a_in;
  logic [15:0] b_in;

  logic [7:0]  sum8;
  logic [3:0]  sum4;
  logic [15:0] sum16;
  logic [2:0]  cout_v;
  logic [2:0]  ovf_v;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [31:0] sum_v [3];

  int n_tests = 0;
  int n_fail  = 0;

  serial_addsub_nbit #(.N(8)) dut8 (
    .clk(clk), .clr(clr), .start(start_v[0]), .sub(sub),
    .a(a_in[7:0]), .b(b_in[7:0]), .sum(sum8),
    .cout(cout_v[0]), .ovf(ovf_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  serial_addsub_nbit #(.N(4)) dut4 (
    .clk(clk), .clr(clr), .start(start_v[1]), .sub(sub),
    .a(a_in[3:0]), .b(b_in[3:0]), .sum(sum4),
    .cout(cout_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  serial_addsub_nbit #(.N(16)) dut16 (
    .clk(clk), .clr(clr), .start(start_v[2]), .sub(sub),
    .a(a_in), .b(b_in), .sum(sum16),
    .cout(cout_v[2]), .ovf(ovf_v[2]), .busy(busy_v[2]), .done(done_v[2])
  );

  always_comb begin
    sum_v[0] = 32'(sum8);
    sum_v[1] = 32'(sum4);
    sum_v[2] = 32'(sum16);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int wid(int k);
    return (k == 0) ? 8 : (k == 1) ? 4 : 16;
  endfunction

  // Reference: plain integer arithmetic on the operand values.
  function automatic res_t model(int n, logic [15:0] a_raw, logic [15:0] b_raw, logic s);
    res_t   r;
    longint m, av, bv, sa, sb, sr;
    m  = longint'(1) << n;
    av = longint'(a_raw) % m;
    bv = longint'(b_raw) % m;
    sa = (av >= m / 2) ? av - m : av;
    sb = (bv >= m / 2) ? bv - m : bv;
    sr = s ? sa - sb : sa + sb;
    r.v = (sr >= m / 2) || (sr < -(m / 2));
    r.c = s ? (av >= bv) : (av + bv >= m);
    r.s = 32'((s ? av - bv + m : av + bv) % m);
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(int k, string tag, res_t e);
    check({tag, " sum"},  sum_v[k],          e.s);
    check({tag, " cout"}, 32'(cout_v[k]),    32'(e.c));
    check({tag, " ovf"},  32'(ovf_v[k]),     32'(e.v));
  endtask

  // One operation on instance k; poke >= 0 re-asserts start with junk operands mid-SHIFT.
  task automatic run_op(int k, logic [15:0] av, logic [15:0] bv, logic s, int poke, string tag);
    res_t e;
    int   cyc;
    int   n;
    n = wid(k);
    e = model(n, av, bv, s);
    a_in = av;
    b_in = bv;
    sub  = s;
    start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    a_in = 16'($urandom);
    b_in = 16'($urandom);
    sub  = 1'($urandom);
    check({tag, " busy after load"}, 32'(busy_v[k]), 32'd1);
    cyc = 0;
    while (busy_v[k] && cyc < 200) begin
      start_v[k] = (cyc == poke);
      @(posedge clk); #1;
      cyc++;
    end
    start_v[k] = 1'b0;
    check({tag, " shift cycles"}, 32'(cyc), 32'(n));
    check({tag, " done"}, 32'(done_v[k]), 32'd1);
    check_outs(k, tag, e);
    @(posedge clk); #1;
    check({tag, " done cleared"}, 32'(done_v[k]), 32'd0);
    check({tag, " idle busy"},    32'(busy_v[k]), 32'd0);
    check({tag, " sum held"},     sum_v[k],       e.s);
  endtask

  initial begin
    res_t e;
    int   cyc;
    clr     = 1'b0;
    start_v = '0;
    sub     = 1'b0;
    a_in    = '0;
    b_in    = '0;
    #3;
    for (int k = 0; k < 3; k++) begin
      check("reset sum",  sum_v[k],       32'd0);
      check("reset cout", 32'(cout_v[k]), 32'd0);
      check("reset ovf",  32'(ovf_v[k]),  32'd0);
      check("reset busy", 32'(busy_v[k]), 32'd0);
      check("reset done", 32'(done_v[k]), 32'd0);
    end
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    check("no start after clr release", 32'(busy_v[0]), 32'd0);

    // Directed N=8 cases.
    run_op(0, 16'h35, 16'h4A, 1'b0, -1, "add 35+4A");
    run_op(0, 16'hFF, 16'h01, 1'b0, -1, "add FF+01");
    run_op(0, 16'h7F, 16'h01, 1'b0, -1, "add 7F+01");
    run_op(0, 16'h03, 16'h05, 1'b1, -1, "sub 03-05");
    run_op(0, 16'h80, 16'h01, 1'b1, -1, "sub 80-01");

    // clr pulsed at shift 4: outputs clear at once, no done pulse.
    a_in = 16'h12; b_in = 16'h34; sub = 1'b0; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    clr = 1'b0;
    #1;
    check("abort sum",  sum_v[0],       32'd0);
    check("abort cout", 32'(cout_v[0]), 32'd0);
    check("abort ovf",  32'(ovf_v[0]),  32'd0);
    check("abort busy", 32'(busy_v[0]), 32'd0);
    check("abort done", 32'(done_v[0]), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort done stays low", 32'(done_v[0]), 32'd0);
    clr = 1'b1;
    @(posedge clk); #1;
    check("abort no done after release", 32'(done_v[0]), 32'd0);
    check("abort no self-start",         32'(busy_v[0]), 32'd0);
    run_op(0, 16'hC3, 16'h5A, 1'b1, -1, "post-abort sub");

    // start re-asserted during SHIFT is ignored.
    run_op(0, 16'h21, 16'h13, 1'b0, 2, "restart ignored");

    // Back-to-back on N=4 with start held high: period N+2.
    a_in = 16'h0009; b_in = 16'h0004; sub = 1'b1; start_v[1] = 1'b1;
    e = model(4, 16'h0009, 16'h0004, 1'b1);
    cyc = 0;
    while (!done_v[1] && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b first done", 32'(done_v[1]), 32'd1);
    check_outs(1, "b2b first", e);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done_v[1] && cyc < 50);
    check("b2b period", 32'(cyc), 32'd6);
    check_outs(1, "b2b second", e);
    start_v[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b stops", 32'(busy_v[1]), 32'd0);

    // Random runs.
    for (int i = 0; i < 10; i++)
      run_op(1, 16'($urandom_range(15)), 16'($urandom_range(15)), 1'($urandom), -1, "rand N4");
    for (int i = 0; i < 10; i++)
      run_op(2, 16'($urandom), 16'($urandom), 1'($urandom), (i == 3) ? 5 : -1, "rand N16");
    for (int i = 0; i < 6; i++)
      run_op(0, 16'($urandom_range(255)), 16'($urandom_range(255)), 1'($urandom), -1, "rand N8");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
